// File: rtl/ita_output_writer.sv
// Serializes N-element ITA output vectors into OW-bit write beats with strided byte
// addresses. The host programs one output tile at a time through a start/busy/done interface.
module ita_output_writer #(
    parameter int unsigned N  = 16,
    parameter int unsigned WI = 8,
    parameter int unsigned OW = 64,
    parameter int unsigned AW = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [AW-1:0]     base_addr_i,
    input  logic [AW-1:0]     stride_i,
    input  logic [15:0]       num_vec_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              inp_valid_i,
    output logic              inp_ready_o,
    input  logic [N*WI-1:0]   inp_data_i,
    output logic              oup_valid_o,
    input  logic              oup_ready_i,
    output logic [OW-1:0]     oup_data_o,
    output logic [AW-1:0]     oup_addr_o,
    output logic [OW/8-1:0]   oup_strb_o,
    output logic              oup_last_o
);

    localparam int unsigned VW    = N * WI;
    localparam int unsigned BEATS = VW / OW;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SW    = OW / 8;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic            done_q, done_d;
    logic            full_q;
    logic [VW-1:0]   vec_q;
    logic [BW-1:0]   beat_cnt_q;
    logic [15:0]     vec_cnt_q;
    logic [15:0]     acc_cnt_q;
    logic [15:0]     num_vec_q;
    logic [AW-1:0]   vec_base_q;
    logic [AW-1:0]   stride_q;

    logic            out_fire;
    logic            last_beat;
    logic            last_vec;
    logic            vec_done;
    logic            job_done;
    logic            in_fire;
    logic            job_load;

    assign out_fire  = full_q & oup_ready_i;
    assign last_beat = (beat_cnt_q == BW'(BEATS - 1));
    assign last_vec  = (vec_cnt_q == num_vec_q - 16'd1);
    assign vec_done  = out_fire & last_beat;
    assign job_done  = vec_done & last_vec;
    assign in_fire   = inp_valid_i & inp_ready_o;
    assign job_load  = (state_q == IDLE) & start_i & (num_vec_i != 16'd0);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        inp_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_vec_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Refill in the same cycle the last beat leaves, so vectors stream without a bubble.
                inp_ready_o = (acc_cnt_q < num_vec_q) && (!full_q || vec_done);
                if (job_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the vector register is reset too, because the beat data outputs must read 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q     <= 1'b0;
            vec_q      <= '0;
            beat_cnt_q <= '0;
            vec_cnt_q  <= '0;
            acc_cnt_q  <= '0;
            num_vec_q  <= '0;
            vec_base_q <= '0;
            stride_q   <= '0;
        end else begin
            if (job_load) begin
                num_vec_q  <= num_vec_i;
                stride_q   <= stride_i;
                vec_base_q <= base_addr_i;
                beat_cnt_q <= '0;
                vec_cnt_q  <= '0;
                acc_cnt_q  <= '0;
            end
            if (in_fire) begin
                vec_q     <= inp_data_i;
                acc_cnt_q <= acc_cnt_q + 16'd1;
            end
            full_q <= in_fire | (full_q & ~vec_done);
            if (out_fire) begin
                if (last_beat) begin
                    beat_cnt_q <= '0;
                    vec_cnt_q  <= vec_cnt_q + 16'd1;
                    vec_base_q <= vec_base_q + stride_q;
                end else begin
                    beat_cnt_q <= beat_cnt_q + BW'(1);
                end
            end
        end
    end

    assign busy_o      = (state_q == RUN);
    assign done_o      = done_q;
    assign oup_valid_o = full_q;
    assign oup_data_o  = vec_q[beat_cnt_q*OW +: OW];
    assign oup_addr_o  = vec_base_q + AW'(beat_cnt_q) * AW'(SW);
    assign oup_strb_o  = {SW{full_q}};
    assign oup_last_o  = full_q & last_beat & last_vec;

endmodule

// File: tb/tb_ita_output_writer.sv
// Directed bench for ita_output_writer: expected beats are queued by the stimulus and
// a monitor compares every presented beat against the head of that queue.
module tb_ita_output_writer;

    typedef struct {
        logic [63:0] data;
        logic [31:0] addr;
        logic        last;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [31:0]   base_addr_i = '0;
    logic [31:0]   stride_i = '0;
    logic [15:0]   num_vec_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          inp_valid_i = 1'b0;
    logic          inp_ready_o;
    logic [127:0]  inp_data_i = '0;
    logic          oup_valid_o;
    logic          oup_ready_i = 1'b0;
    logic [63:0]   oup_data_o;
    logic [31:0]   oup_addr_o;
    logic [7:0]    oup_strb_o;
    logic          oup_last_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    beat_t exp_q[$];

    localparam logic [127:0] VA = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] VB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] VC = 128'hdead_beef_0bad_f00d_cafe_babe_8001_7fff;

    ita_output_writer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .num_vec_i   (num_vec_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (inp_ready_o),
        .inp_data_i  (inp_data_i),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .oup_data_o  (oup_data_o),
        .oup_addr_o  (oup_addr_o),
        .oup_strb_o  (oup_strb_o),
        .oup_last_o  (oup_last_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every presented beat must equal the queue head; it is popped only on handshake.
    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
        if (oup_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                check("beat_data", oup_data_o, exp_q[0].data);
                check("beat_addr", 64'(oup_addr_o), 64'(exp_q[0].addr));
                check("beat_last", 64'(oup_last_o), 64'(exp_q[0].last));
                check("beat_strb", 64'(oup_strb_o), 64'hff);
                if (oup_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic exp_vec(input logic [127:0] v, input logic [31:0] a0, input logic [31:0] a1,
                           input logic last);
        beat_t b;
        b.data = v[63:0];   b.addr = a0; b.last = 1'b0; exp_q.push_back(b);
        b.data = v[127:64]; b.addr = a1; b.last = last; exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input logic [31:0] b, input logic [31:0] s, input logic [15:0] n);
        start_i = 1'b1; base_addr_i = b; stride_i = s; num_vec_i = n;
        tick();
        start_i = 1'b0;
    endtask

    task automatic push_vec(input logic [127:0] v);
        bit ok = 0;
        inp_valid_i = 1'b1;
        inp_data_i  = v;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            if (inp_ready_o) begin
                tick();
                ok = 1;
            end
        end
        inp_valid_i = 1'b0;
        if (!ok) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(output int at);
        bit ok = 0;
        at = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                ok = 1;
                at = cyc;
                check("busy_at_done", 64'(busy_o), 64'd0);
            end
        end
        if (!ok) check("done_timeout", 64'd0, 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        int t0;
        int t_done;
        int dc;

        // Reset state
        #3;
        check("rst_valid", 64'(oup_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_ready", 64'(inp_ready_o), 64'd0);
        check("rst_addr", 64'(oup_addr_o), 64'd0);
        check("rst_data", oup_data_o, 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Basic job: three back-to-back vectors, ready held high
        oup_ready_i = 1'b1;
        exp_vec(VA, 32'h1000, 32'h1008, 1'b0);
        exp_vec(VB, 32'h1040, 32'h1048, 1'b0);
        exp_vec(VC, 32'h1080, 32'h1088, 1'b1);
        start_job(32'h1000, 32'h40, 16'd3);
        t0 = cyc;
        push_vec(VA);
        push_vec(VB);
        push_vec(VC);
        wait_done(t_done);
        check("basic_done_cycle", 64'(t_done), 64'(t0 + 7));

        // Zero-length job with input offered
        inp_valid_i = 1'b1;
        inp_data_i  = VA;
        start_job(32'h2000, 32'h40, 16'd0);
        @(negedge clk_i);
        check("zero_done", 64'(done_o), 64'd1);
        check("zero_busy", 64'(busy_o), 64'd0);
        check("zero_ready", 64'(inp_ready_o), 64'd0);
        tick();
        @(negedge clk_i);
        check("zero_done_pulse", 64'(done_o), 64'd0);
        check("zero_busy_after", 64'(busy_o), 64'd0);
        inp_valid_i = 1'b0;
        tick();

        // Output backpressure: ready pattern 1,0,0,1 while a second vector waits
        oup_ready_i = 1'b0;
        exp_vec(VB, 32'h2000, 32'h2008, 1'b0);
        exp_vec(VC, 32'h2040, 32'h2048, 1'b1);
        start_job(32'h2000, 32'h40, 16'd2);
        push_vec(VB);
        inp_valid_i = 1'b1;
        inp_data_i  = VC;
        oup_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_inready_b0", 64'(inp_ready_o), 64'd0);
        tick();
        oup_ready_i = 1'b0;
        @(negedge clk_i);
        check("bp_inready_stall1", 64'(inp_ready_o), 64'd0);
        tick();
        @(negedge clk_i);
        check("bp_inready_stall2", 64'(inp_ready_o), 64'd0);
        tick();
        oup_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_inready_refill", 64'(inp_ready_o), 64'd1);
        tick();
        inp_valid_i = 1'b0;
        wait_done(t_done);

        // Address wrap
        exp_vec(VC, 32'hFFFF_FFF8, 32'h0000_0000, 1'b0);
        exp_vec(VA, 32'h0000_0000, 32'h0000_0008, 1'b1);
        start_job(32'hFFFF_FFF8, 32'h8, 16'd2);
        push_vec(VC);
        push_vec(VA);
        wait_done(t_done);

        // Reset mid-job after one of two beats
        oup_ready_i = 1'b0;
        exp_vec(VB, 32'h5000, 32'h5008, 1'b1);
        start_job(32'h5000, 32'h40, 16'd1);
        push_vec(VB);
        oup_ready_i = 1'b1;
        tick();
        oup_ready_i = 1'b0;
        dc = done_cnt;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid", 64'(oup_valid_o), 64'd0);
        check("midrst_data", oup_data_o, 64'd0);
        check("midrst_addr", 64'(oup_addr_o), 64'd0);
        check("midrst_last", 64'(oup_last_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        check("midrst_no_done", 64'(done_cnt), 64'(dc));
        oup_ready_i = 1'b1;
        exp_vec(VA, 32'h3000, 32'h3008, 1'b1);
        start_job(32'h3000, 32'h10, 16'd1);
        push_vec(VA);
        wait_done(t_done);

        // Input offered in Idle, then start pulses while busy
        inp_valid_i = 1'b1;
        inp_data_i  = VC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("idle_ready", 64'(inp_ready_o), 64'd0);
            check("idle_valid", 64'(oup_valid_o), 64'd0);
            tick();
        end
        exp_vec(VA, 32'h4000, 32'h4008, 1'b0);
        exp_vec(VB, 32'h4100, 32'h4108, 1'b1);
        start_job(32'h4000, 32'h100, 16'd2);
        push_vec(VA);
        start_i = 1'b1; base_addr_i = 32'h9000; stride_i = 32'h8; num_vec_i = 16'd5;
        push_vec(VB);
        start_i = 1'b0;
        wait_done(t_done);
        inp_valid_i = 1'b1;
        @(negedge clk_i);
        check("post_job_idle_ready", 64'(inp_ready_o), 64'd0);
        check("post_job_busy", 64'(busy_o), 64'd0);
        inp_valid_i = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
